sand_mem_slave: RTL

SAND_MEM_SLAVE -- requirements
Module: sand_mem_slave

---
 rtl/sand_pkg.sv | 22 ++
 rtl/sand_mem_array.sv | 39 +++
 rtl/sand_mem_slave.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sand_pkg.sv
// Shared definitions for the sand memory slave.
//   SAND_ADDR_W / SAND_DATA_W : bus address and data widths
//   SAND_COLS                 : text-console column count used elsewhere in the codebase
//   sand_mem_state_t          : slave FSM state encoding
//   sand_idx_w()              : index width for a table of N entries (never below 1)
package sand_pkg;

    localparam int unsigned SAND_ADDR_W = 24;
    localparam int unsigned SAND_DATA_W = 16;
    localparam int unsigned SAND_COLS   = 80;

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StReady = 2'd1,
        StStall = 2'd2
    } sand_mem_state_t;

    function automatic int unsigned sand_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sand_mem_array.sv
// Single-port synchronous RAM: one read or one write per cycle, registered read data.
// Ports:
//   clock : posedge clock
//   en    : port enable (read when we=0, write when we=1)
//   we    : write enable
//   addr  : word index
//   wdata : write payload
//   rdata : read data, valid the cycle after a read
module sand_mem_array
    import sand_pkg::*;
#(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned IDX_W = sand_idx_w(WORDS)
) (
    input  logic                   clock,
    input  logic                   en,
    input  logic                   we,
    input  logic [IDX_W-1:0]       addr,
    input  logic [SAND_DATA_W-1:0] wdata,
    output logic [SAND_DATA_W-1:0] rdata
);

    logic [SAND_DATA_W-1:0] mem_q [WORDS];
    logic [SAND_DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sand_mem_slave.sv
// Pipelined memory slave with periodic back-pressure windows.
// Optional feature macro: SAND_MEM_CLEAR_EN -- after reset, zero-fill the whole array
// (one word per cycle, waitrequest held) before accepting requests.
// Ports:
//   clock, reset              : single clock, synchronous active-high reset
//   mem_address/read/write    : request (held by the master while waitrequest is high)
//   mem_writedata             : write payload
//   mem_waitrequest           : high = request not accepted this cycle
//   mem_readdatavalid/readdata: one pulse per accepted read, READ_LATENCY cycles later
module sand_mem_slave
    import sand_pkg::*;
#(
    parameter int unsigned ADDR_WORDS   = 4096,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STALL_PERIOD = 64,
    parameter int unsigned STALL_LEN    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SAND_ADDR_W-1:0] mem_address,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [SAND_DATA_W-1:0] mem_writedata,
    output logic                   mem_waitrequest,
    output logic                   mem_readdatavalid,
    output logic [SAND_DATA_W-1:0] mem_readdata
);

    localparam int unsigned IDX_W     = sand_idx_w(ADDR_WORDS);
    localparam int unsigned CNT_W     = sand_idx_w(STALL_PERIOD);
    localparam bit          STALLS_EN = (STALL_PERIOD != 0) && (STALL_LEN != 0);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STALL_PERIOD - 1);
    localparam logic [CNT_W-1:0] STALL_START = CNT_W'(STALL_PERIOD - STALL_LEN);

    sand_mem_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;   // low while in reset; first low-to-high edge starts the FSM
    logic             wait_q;

    logic in_range, accept, do_write, do_read;

    assign in_range = ({8'd0, mem_address} < 32'(ADDR_WORDS));
    assign accept   = (mem_read | mem_write) & ~mem_waitrequest;
    assign do_write = accept & mem_write;
    assign do_read  = accept & mem_read & ~mem_write;   // write wins when both are high

`ifdef SAND_MEM_CLEAR_EN
    logic [IDX_W-1:0] clr_q;
    logic             clearing;

    assign clearing = run_q & (state_q == StClear);

    always_ff @(posedge clock) begin
        if (reset) begin
            clr_q <= '0;
        end else if (clearing) begin
            clr_q <= clr_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run_q) begin
`ifdef SAND_MEM_CLEAR_EN
            state_d = StClear;
`else
            state_d = StReady;
`endif
            cnt_d = '0;
        end else begin
            case (state_q)
`ifdef SAND_MEM_CLEAR_EN
                StClear: begin
                    if (clr_q == IDX_W'(ADDR_WORDS - 1)) begin
                        state_d = StReady;
                    end
                end
`endif
                default: begin
                    if (STALLS_EN) begin
                        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                        state_d = (cnt_d >= STALL_START) ? StStall : StReady;
                    end
                end
            endcase
        end
    end

    // state_q is a don't-care during reset; wait_q alone holds off the master.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_q   <= 1'b0;
            state_q <= StReady;
            cnt_q   <= '0;
            wait_q  <= 1'b1;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= (state_d != StReady);
        end
    end

    // Reset forces waitrequest high immediately, so nothing is accepted during a reset cycle.
    assign mem_waitrequest = wait_q | reset;

    // Array port: clear sweep owns it while clearing (no requests are accepted then).
    logic                   arr_en, arr_we;
    logic [IDX_W-1:0]       arr_addr;
    logic [SAND_DATA_W-1:0] arr_wdata, arr_rdata;

    always_comb begin
        arr_en    = (do_write & in_range) | do_read;
        arr_we    = do_write;
        arr_addr  = mem_address[IDX_W-1:0];
        arr_wdata = mem_writedata;
`ifdef SAND_MEM_CLEAR_EN
        if (clearing) begin
            arr_en    = 1'b1;
            arr_we    = 1'b1;
            arr_addr  = clr_q;
            arr_wdata = '0;
        end
`endif
    end

    sand_mem_array #(
        .WORDS (ADDR_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clock (clock),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Stage 0 aligns with the array's registered read; out-of-range reads are forced to zero.
    logic                   rd_vld_q, rd_oor_q;
    logic [SAND_DATA_W-1:0] stage0_dat;
    logic                   out_vld;
    logic [SAND_DATA_W-1:0] out_dat;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            rd_vld_q <= do_read;
            rd_oor_q <= ~in_range;
        end
    end

    assign stage0_dat = rd_oor_q ? '0 : arr_rdata;

    if (READ_LATENCY > 1) begin : g_dly
        localparam int unsigned DLY = READ_LATENCY - 1;
        logic [DLY-1:0]         vld_q;
        logic [SAND_DATA_W-1:0] dat_q [DLY];

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= rd_vld_q;
                for (int i = 1; i < DLY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        always_ff @(posedge clock) begin
            dat_q[0] <= stage0_dat;
            for (int i = 1; i < DLY; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
        end

        assign out_vld = vld_q[DLY-1];
        assign out_dat = dat_q[DLY-1];
    end else begin : g_nodly
        assign out_vld = rd_vld_q;
        assign out_dat = stage0_dat;
    end

    // Gating with reset suppresses a pulse already in flight when reset rises mid-cycle.
    assign mem_readdatavalid = out_vld & ~reset;
    assign mem_readdata      = mem_readdatavalid ? out_dat : '0;

endmodule
